// File: rtl/rand_walk_integrator.sv
// Random-walk integrator: acceleration -> saturating velocity -> bouncing position.
// One update per accepted step, reported with a single-cycle update_valid pulse.
module rand_walk_integrator #(
    parameter int VEL_W    = 8,
    parameter int VEL_MAX  = 15,
    parameter int POS_W    = 10,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = 639,
    parameter int POS_INIT = 320
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    step,
    input  logic signed [3:0]       random_acc,
    output logic signed [VEL_W-1:0] velocity,
    output logic [POS_W-1:0]        position,
    output logic                    update_valid,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEL,
        MOVE,
        DONE
    } state_t;

    localparam logic signed [VEL_W:0]   V_HI = (VEL_W+1)'(VEL_MAX);
    localparam logic signed [VEL_W:0]   V_LO = -V_HI;
    localparam logic signed [POS_W+1:0] P_HI = (POS_W+2)'(POS_MAX);
    localparam logic signed [POS_W+1:0] P_LO = (POS_W+2)'(POS_MIN);

    state_t                  state;
    state_t                  state_n;
    logic signed [3:0]       acc_q;
    logic signed [VEL_W:0]   vel_sum;
    logic signed [VEL_W-1:0] vel_clamp;
    logic signed [POS_W+1:0] pos_sum;
    logic                    accept;
    logic                    in_flight;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (step) state_n = ACCEL;
            ACCEL: state_n = MOVE;
            MOVE:  state_n = DONE;
            DONE:  state_n = step ? ACCEL : IDLE;
        endcase
    end

    assign accept    = step && ((state == IDLE) || (state == DONE));
    assign in_flight = (state == ACCEL) || (state == MOVE);

    always_comb begin
        vel_sum = {velocity[VEL_W-1], velocity}
                + {{(VEL_W-3){acc_q[3]}}, acc_q};
        vel_clamp = vel_sum[VEL_W-1:0];
        if (vel_sum > V_HI)      vel_clamp = V_HI[VEL_W-1:0];
        else if (vel_sum < V_LO) vel_clamp = V_LO[VEL_W-1:0];
        pos_sum = {2'b00, position}
                + {{(POS_W+2-VEL_W){velocity[VEL_W-1]}}, velocity};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            velocity     <= '0;
            position     <= POS_W'(POS_INIT);
            acc_q        <= '0;
            update_valid <= 1'b0;
            busy         <= 1'b0;
            drop_count   <= '0;
        end else begin
            update_valid <= (state_n == DONE);
            busy         <= (state_n == ACCEL) || (state_n == MOVE);
            // -8 would make the range asymmetric, so it is folded to zero
            if (accept)
                acc_q <= (random_acc == 4'sb1000) ? 4'sd0 : random_acc;
            if (state == ACCEL)
                velocity <= vel_clamp;
            if (state == MOVE) begin
                if (pos_sum > P_HI) begin
                    position <= P_HI[POS_W-1:0];
                    velocity <= -velocity;
                end else if (pos_sum < P_LO) begin
                    position <= P_LO[POS_W-1:0];
                    velocity <= -velocity;
                end else begin
                    position <= pos_sum[POS_W-1:0];
                end
            end
            if (in_flight && step && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_rand_walk_integrator.sv
// Scoreboard bench for rand_walk_integrator: a reference model pushes the
// expected velocity/position per accepted step; a monitor pops on update_valid.
module tb_rand_walk_integrator;

    logic              clock;
    logic              reset;
    logic              step;
    logic signed [3:0] random_acc;
    logic signed [7:0] velocity;
    logic [9:0]        position;
    logic              update_valid;
    logic              busy;
    logic [7:0]        drop_count;

    rand_walk_integrator dut (
        .clock        (clock),
        .reset        (reset),
        .step         (step),
        .random_acc   (random_acc),
        .velocity     (velocity),
        .position     (position),
        .update_valid (update_valid),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    typedef struct {
        int v;
        int p;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   mvel;
    int   mpos;
    int   pulses;
    int   n_checks;
    int   n_pass;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic void model_push(input logic [3:0] acc);
        int a, v, p;
        a = $signed(acc);
        if (a == -8) a = 0;
        v = mvel + a;
        if (v > 15)  v = 15;
        if (v < -15) v = -15;
        p = mpos + v;
        if (p > 639) begin
            p = 639;
            v = -v;
        end else if (p < 0) begin
            p = 0;
            v = -v;
        end
        mvel = v;
        mpos = p;
        sb.push_back('{v, p});
    endfunction

    always @(negedge clock) begin
        if (!reset && update_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_vel", int'(velocity), e.v);
                check("sb_pos", int'(position), e.p);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        step  = 1'b0;
        sb.delete();
        mvel = 0;
        mpos = 320;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("timeout", sb.size(), 0);
        @(negedge clock);
    endtask

    task automatic send(input logic [3:0] acc);
        step       = 1'b1;
        random_acc = acc;
        model_push(acc);
        @(negedge clock);
        step = 1'b0;
        wait_done();
    endtask

    initial begin
        int p0;
        n_checks   = 0;
        n_pass     = 0;
        pulses     = 0;
        reset      = 1'b1;
        step       = 1'b0;
        random_acc = '0;
        do_reset();

        check("rst_vel", int'(velocity), 0);
        check("rst_pos", int'(position), 320);
        check("rst_valid", int'(update_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop_count), 0);

        // single step, cycle by cycle
        step       = 1'b1;
        random_acc = 4'sd3;
        model_push(4'b0011);
        @(negedge clock);
        step = 1'b0;
        check("busy_c1", int'(busy), 1);
        @(negedge clock);
        check("busy_c2", int'(busy), 1);
        check("vel_early", int'(velocity), 3);
        @(negedge clock);
        check("busy_c3", int'(busy), 0);
        check("valid_c3", int'(update_valid), 1);
        @(negedge clock);
        check("valid_c4", int'(update_valid), 0);
        check("t1_vel", int'(velocity), 3);
        check("t1_pos", int'(position), 323);
        check("t1_drop", int'(drop_count), 0);

        // clamp at +15 and -8 folded to zero
        send(4'd7);
        send(4'd4);
        check("pre_vel", int'(velocity), 14);
        send(4'd5);
        check("clamp_hi", int'(velocity), 15);
        send(4'b1000);
        check("neg8_zero", int'(velocity), 15);
        check("neg8_pos", int'(position), 377);

        // bounce at the upper bound
        do_reset();
        send(4'd7);
        send(4'b1110);
        for (int i = 0; i < 61; i++) send(4'd0);
        check("hi_setup_pos", int'(position), 637);
        check("hi_setup_vel", int'(velocity), 5);
        send(4'd0);
        check("hi_bounce_pos", int'(position), 639);
        check("hi_bounce_vel", int'(velocity), -5);

        // bounce at the lower bound
        send(4'b1110);
        send(4'd2);
        for (int i = 0; i < 125; i++) send(4'd0);
        check("lo_setup_pos", int'(position), 2);
        check("lo_setup_vel", int'(velocity), -5);
        send(4'd0);
        check("lo_bounce_pos", int'(position), 0);
        check("lo_bounce_vel", int'(velocity), 5);

        // back-to-back steps, only in IDLE/DONE cycles
        p0 = pulses;
        for (int i = 0; i < 30; i++) begin
            step = (i % 3 == 0);
            if (i % 3 == 0) begin
                random_acc = ((i / 3) % 2 == 0) ? 4'sd4 : -4'sd3;
                model_push(random_acc);
            end
            @(negedge clock);
        end
        step = 1'b0;
        wait_done();
        check("b2b_pulses", pulses - p0, 10);
        check("b2b_drop", int'(drop_count), 0);

        // step repeated during ACCEL is dropped
        step       = 1'b1;
        random_acc = 4'sd2;
        model_push(4'd2);
        @(negedge clock);
        random_acc = 4'sd7;
        @(negedge clock);
        step = 1'b0;
        wait_done();
        check("drop_one", int'(drop_count), 1);

        // held step: two drops per update, saturating
        for (int i = 0; i < 450; i++) begin
            step       = 1'b1;
            random_acc = 4'($urandom_range(0, 15));
            if (i % 3 == 0) model_push(random_acc);
            @(negedge clock);
        end
        step = 1'b0;
        wait_done();
        check("drop_sat", int'(drop_count), 255);

        // reset while in MOVE abandons the update
        step       = 1'b1;
        random_acc = 4'sd6;
        @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        mvel  = 0;
        mpos  = 320;
        @(negedge clock);
        reset = 1'b0;
        check("abort_pos", int'(position), 320);
        check("abort_vel", int'(velocity), 0);
        check("abort_valid", int'(update_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_drop", int'(drop_count), 0);
        p0 = pulses;
        repeat (4) @(negedge clock);
        check("abort_no_pulse", pulses - p0, 0);
        send(4'd2);
        check("post_abort_pos", int'(position), 322);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
